// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: refresh prescaler, digit slot scan,
// PWM brightness, per-digit blanking / decimal points / leading-zero
// suppression, and a double-buffered display image committed at frame ends.
module seg7_scan_ctrl #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned PRESCALE   = 64,
    parameter int unsigned BRIGHT_W   = 4,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lz_en,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int unsigned CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned ON_W   = $clog2(PRESCALE + 1);
    localparam int unsigned SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DATA_W = 4 * DIGITS;

    localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW}};
    localparam logic              DP_OFF  = ACTIVE_LOW;

    logic [CNT_W-1:0]  pre_cnt;
    logic [SLOT_W-1:0] slot;
    logic [ON_W-1:0]   on_lat;

    logic [DATA_W-1:0] disp_data, pend_data;
    logic [DIGITS-1:0] disp_dp, pend_dp;
    logic [DIGITS-1:0] disp_blank, pend_blank;

    logic              tick_c;
    logic              frame_end_c;
    logic [ON_W-1:0]   on_calc_c;
    logic [ON_W-1:0]   on_eff_c;
    logic              pwm_on_c;
    logic [DIGITS-1:0] lz_dark_c;
    logic              all_zero_c;
    logic [3:0]        nib_c;
    logic              dark_c;
    logic [DIGITS-1:0] an_on_c;
    logic [6:0]        seg_nx_c;
    logic              dp_nx_c;
    logic [DIGITS-1:0] an_nx_c;

    // Hex glyph in active-low form (0 = segment lit), order a..g.
    function automatic logic [6:0] glyph_n(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    // Timing strobes and PWM on-window for the current slot.
    always_comb begin
        tick_c      = (pre_cnt == CNT_W'(PRESCALE - 1));
        frame_end_c = tick_c && (slot == SLOT_W'(DIGITS - 1));
        on_calc_c   = ON_W'(((32'(bright) + 32'd1) * PRESCALE) >> BRIGHT_W);
        on_eff_c    = (pre_cnt == '0) ? on_calc_c : on_lat;
        pwm_on_c    = (ON_W'(pre_cnt) < on_eff_c);
    end

    // Leading-zero mask: digit k goes dark when it and every higher nibble is zero.
    always_comb begin
        all_zero_c = 1'b1;
        lz_dark_c  = '0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            all_zero_c = all_zero_c && (disp_data[4*k +: 4] == 4'd0);
            if (k > 0) begin
                lz_dark_c[k] = lz_en && all_zero_c;
            end
        end
    end

    // Next output image for the digit in the current slot.
    always_comb begin
        nib_c   = disp_data[{slot, 2'b00} +: 4];
        dark_c  = disp_blank[slot] || lz_dark_c[slot];
        an_on_c = '0;
        if (!dark_c && pwm_on_c) begin
            an_on_c[slot] = 1'b1;
        end
        seg_nx_c = dark_c ? 7'h7F : glyph_n(nib_c);
        dp_nx_c  = !(disp_dp[slot] && !dark_c);
        an_nx_c  = ~an_on_c;
        if (!ACTIVE_LOW) begin
            seg_nx_c = ~seg_nx_c;
            dp_nx_c  = ~dp_nx_c;
            an_nx_c  = an_on_c;
        end
    end

    // Prescaler, slot counter and slot-start brightness latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            slot    <= '0;
            on_lat  <= '0;
        end else begin
            if (pre_cnt == '0) begin
                on_lat <= on_calc_c;
            end
            if (tick_c) begin
                pre_cnt <= '0;
                slot    <= (slot == SLOT_W'(DIGITS - 1)) ? '0 : slot + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    // Pending/display double buffer; commit happens only at a frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_data  <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pending    <= 1'b0;
        end else begin
            if (frame_end_c && pending) begin
                disp_data  <= pend_data;
                disp_dp    <= pend_dp;
                disp_blank <= pend_blank;
            end
            if (load) begin
                pend_data  <= data_in;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
                pending    <= 1'b1;
            end else if (frame_end_c) begin
                pending    <= 1'b0;
            end
        end
    end

    // Registered pin drivers and frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_nx_c;
            dp         <= dp_nx_c;
            an         <= an_nx_c;
            frame_done <= frame_end_c;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: per-cycle reference model plus table-driven
// frame measurements and hand-written load/commit/reset sequences.
module tb_seg7_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 8;
    localparam int BRIGHT_W = 2;
    localparam int FRAME    = DIGITS * PRESCALE;

    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_en;
    logic [1:0]  bright;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .DIGITS(DIGITS), .PRESCALE(PRESCALE), .BRIGHT_W(BRIGHT_W), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
        .blank_in(blank_in), .lz_en(lz_en), .bright(bright), .seg(seg), .dp(dp),
        .an(an), .pending(pending), .frame_done(frame_done)
    );

    // Reference model: edges since reset, plus the two buffer images.
    int unsigned n;
    int          m_on;
    logic [15:0] m_disp_d, m_pend_d;
    logic [3:0]  m_disp_dp, m_pend_dp, m_disp_bl, m_pend_bl;
    logic        m_pf;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_one_glyph = 0;

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      dpv;
        logic [3:0]      blank;
        logic            lz;
        logic [1:0]      br;
        logic [3:0][3:0] on_cnt;
        logic [3:0][6:0] seg_at;
        logic [3:0]      dp_at;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t n=%0d)", name, act, exp, $time, n);
        end
    endtask

    task automatic model_reset();
        n = 0; m_on = 0; m_pf = 1'b0;
        m_disp_d = '0; m_pend_d = '0;
        m_disp_dp = '0; m_pend_dp = '0; m_disp_bl = '0; m_pend_bl = '0;
    endtask

    // One clock edge: predict outputs from the pre-edge state, advance model, compare.
    task automatic step();
        int p, s;
        logic dark, bnd, e_dp;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        p = int'(n % PRESCALE);
        s = int'((n / PRESCALE) % DIGITS);
        if (p == 0) m_on = ((int'(bright) + 1) * PRESCALE) >> BRIGHT_W;
        dark  = m_disp_bl[s] || (lz_en && s > 0 && ((m_disp_d >> (4 * s)) == 16'd0));
        e_an  = 4'hF;
        if (!dark && p < m_on) e_an[s] = 1'b0;
        e_seg = dark ? 7'h7F : GLYPH[m_disp_d[4*s +: 4]];
        e_dp  = !(m_disp_dp[s] && !dark);
        bnd   = (n % FRAME) == FRAME - 1;
        if (bnd && m_pf) begin
            m_disp_d = m_pend_d; m_disp_dp = m_pend_dp; m_disp_bl = m_pend_bl;
        end
        if (load) begin
            m_pend_d = data_in; m_pend_dp = dp_in; m_pend_bl = blank_in; m_pf = 1'b1;
        end else if (bnd) begin
            m_pf = 1'b0;
        end
        n++;
        @(posedge clk);
        #1;
        chk("seg", 32'(seg), 32'(e_seg));
        chk("an", 32'(an), 32'(e_an));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("frame_done", 32'(frame_done), 32'(bnd));
        chk("pending", 32'(pending), 32'(m_pf));
        if (seg == 7'b1001111) cnt_one_glyph++;
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < FRAME + 1 && int'(n % FRAME) != target; k++) step();
        chk("run_to_reached", 32'(n % FRAME), 32'(target));
    endtask

    task automatic wait_fd();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 3 * FRAME && !got; k++) begin
            step();
            got = frame_done;
        end
        chk("frame_done_timeout", 32'(got), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_hold_an", 32'(an), 32'hF);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3, {4'd8,4'd8,4'd8,4'd8},
                    {7'b1001111,7'b0010010,7'b0001000,7'b0111000}, 4'hF};
        vecs[1] = '{16'h8888, 4'h0, 4'h0, 1'b0, 2'd0, {4'd2,4'd2,4'd2,4'd2},
                    {7'b0000000,7'b0000000,7'b0000000,7'b0000000}, 4'hF};
        vecs[2] = '{16'h8888, 4'h0, 4'h0, 1'b0, 2'd2, {4'd6,4'd6,4'd6,4'd6},
                    {7'b0000000,7'b0000000,7'b0000000,7'b0000000}, 4'hF};
        vecs[3] = '{16'h8888, 4'h0, 4'h0, 1'b0, 2'd1, {4'd4,4'd4,4'd4,4'd4},
                    {7'b0000000,7'b0000000,7'b0000000,7'b0000000}, 4'hF};
        vecs[4] = '{16'h0030, 4'h0, 4'h0, 1'b1, 2'd3, {4'd0,4'd0,4'd8,4'd8},
                    {7'h7F,7'h7F,7'b0000110,7'b0000001}, 4'hF};
        vecs[5] = '{16'h0000, 4'h0, 4'h0, 1'b1, 2'd3, {4'd0,4'd0,4'd0,4'd8},
                    {7'h7F,7'h7F,7'h7F,7'b0000001}, 4'hF};
        vecs[6] = '{16'h5555, 4'b0001, 4'b0100, 1'b0, 2'd3, {4'd8,4'd0,4'd8,4'd8},
                    {7'b0100100,7'h7F,7'b0100100,7'b0100100}, 4'b1110};
        vecs[7] = '{16'h0030, 4'b1000, 4'h0, 1'b1, 2'd3, {4'd0,4'd0,4'd8,4'd8},
                    {7'h7F,7'h7F,7'b0000110,7'b0000001}, 4'hF};

        rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; blank_in = '0;
        lz_en = 1'b0; bright = 2'd3;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Table: load, hold pending until the commit, then measure one full frame.
        for (int v = 0; v < 8; v++) begin
            int lows[4];
            int fd_cnt, fd_pos;
            logic [3:0][6:0] seg_seen;
            logic [3:0] dp_seen;
            logic got;
            bright = vecs[v].br; lz_en = vecs[v].lz;
            data_in = vecs[v].data; dp_in = vecs[v].dpv; blank_in = vecs[v].blank;
            load = 1'b1;
            step();
            load = 1'b0;
            chk("vec_pending_set", 32'(pending), 32'd1);
            got = 1'b0;
            for (int k = 0; k < 3 * FRAME && !got; k++) begin
                step();
                got = frame_done;
                if (!got) chk("vec_pending_hold", 32'(pending), 32'd1);
            end
            chk("vec_commit_seen", 32'(got), 32'd1);
            chk("vec_pending_clear", 32'(pending), 32'd0);
            for (int k = 0; k < 4; k++) lows[k] = 0;
            fd_cnt = 0; fd_pos = -1; seg_seen = '0; dp_seen = '0;
            for (int i = 0; i < FRAME; i++) begin
                step();
                for (int k = 0; k < 4; k++) if (!an[k]) lows[k]++;
                if (i % PRESCALE == 0) begin
                    seg_seen[i / PRESCALE] = seg;
                    dp_seen[i / PRESCALE]  = dp;
                end
                if (frame_done) begin fd_cnt++; fd_pos = i; end
            end
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("vec%0d_on_cycles_d%0d", v, k), 32'(lows[k]), 32'(vecs[v].on_cnt[k]));
                chk($sformatf("vec%0d_seg_d%0d", v, k), 32'(seg_seen[k]), 32'(vecs[v].seg_at[k]));
            end
            chk($sformatf("vec%0d_dp", v), 32'(dp_seen), 32'(vecs[v].dp_at));
            chk($sformatf("vec%0d_fd_count", v), 32'(fd_cnt), 32'd1);
            chk($sformatf("vec%0d_fd_pos", v), 32'(fd_pos), 32'(FRAME - 1));
        end

        // Two loads within a frame: the last one wins, the first never appears.
        lz_en = 1'b0; bright = 2'd3; dp_in = '0; blank_in = '0;
        cnt_one_glyph = 0;
        run_to(5);
        data_in = 16'h1111; load = 1'b1; step(); load = 1'b0;
        run_to(12);
        data_in = 16'h2222; load = 1'b1; step(); load = 1'b0;
        wait_fd();
        step();
        chk("t5_last_load_wins", 32'(seg), 32'(7'b0010010));
        run_to(0);
        chk("t5_1111_never_shown", 32'(cnt_one_glyph), 32'd0);

        // Load on the boundary cycle: old pending shows first, new data a frame later.
        run_to(10);
        data_in = 16'h4444; load = 1'b1; step(); load = 1'b0;
        run_to(FRAME - 1);
        data_in = 16'h3333; load = 1'b1; step(); load = 1'b0;
        chk("t5_bnd_align", 32'(frame_done), 32'd1);
        chk("t5_pend_kept", 32'(pending), 32'd1);
        step();
        chk("t5_old_pending_shown", 32'(seg), 32'(7'b1001100));
        run_to(FRAME - 1);
        step();
        chk("t5_pending_cleared", 32'(pending), 32'd0);
        step();
        chk("t5_new_commits", 32'(seg), 32'(7'b0000110));

        // Reset mid-slot 2 with a load pending; scan restarts from slot 0 with cleared data.
        run_to(17);
        data_in = 16'h9876; load = 1'b1; step(); load = 1'b0;
        step();
        chk("t6_pend_before", 32'(pending), 32'd1);
        do_reset();
        step();
        chk("t6_seg0", 32'(seg), 32'(7'b0000001));
        chk("t6_an0", 32'(an), 32'(4'b1110));

        // Randomized traffic against the model, with one reset in the middle.
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            load = ($urandom_range(0, 15) == 0);
            if (load) begin
                data_in  = 16'($urandom) >> $urandom_range(0, 16);
                dp_in    = 4'($urandom);
                blank_in = 4'($urandom) & 4'($urandom);
            end
            if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
            bright = 2'($urandom);
            step();
        end
        load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
